sa_sequencer: RTL and testbench
===============================

SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: array dimension (N x N PE_int8 grid, weight-stationary); N >= 2.
REQ-002 SHALL have parameter VW, default 16: width of vector count and activation address.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a job; sampled only in IDLE.
REQ-006 SHALL have port keep_w  input  1  at start: 1 = skip weight load, reuse resident weights.
REQ-007 SHALL have port num_vecs  input  VW  M, activation vectors in job; latched at accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-010 SHALL have port w_rd_en / w_rd_addr  output  1 / clog2(N)  weight-row memory read, 1-cycle read latency.
REQ-011 SHALL have port pe_load_row  output  N  one-hot; drives load of every PE in row r.
REQ-012 SHALL have port a_rd_en / a_rd_addr  output  1 / VW  activation memory read, 1-cycle read latency.
REQ-013 SHALL have port west_valid  output  N  bit r high when row r's i_west (skewed) carries valid data; external mux drives 0 otherwise.
REQ-014 SHALL have port out_valid  output  N  bit c high when bottom-row o_south of column c holds a valid result.

Function
REQ-015 States SHALL be IDLE, LOAD_W, STREAM; transitions evaluated each rising edge.
REQ-016 IDLE + start: latch M, clear counter k=0; go LOAD_W if keep_w=0, else STREAM if M>0, else pulse done next cycle and stay IDLE.
REQ-017 start while busy SHALL be ignored, no effect on the running job.
REQ-018 LOAD_W SHALL last N+1 cycles, k=0..N: w_rd_en=1, w_rd_addr=k for k<N; pe_load_row=one-hot(k-1) for k>=1, else 0.
REQ-019 Leaving LOAD_W: go STREAM with s=0 if M>0; if M=0 pulse done and return IDLE.
REQ-020 STREAM SHALL use counter s=0..M+2N-1 (VW+2 bits, no wrap): a_rd_en=1, a_rd_addr=s for s<M, else a_rd_en=0.
REQ-021 west_valid[r] SHALL be 1 exactly for s in [1+r, M+r].
REQ-022 out_valid[c] SHALL be 1 exactly for s in [N+1+c, M+N+c]; vector m emerges on column c at s=m+N+1+c.
REQ-023 At s=M+2N-1: return IDLE next cycle with done=1 for that one cycle and busy=0 in the same cycle.
REQ-024 pe_load_row SHALL be all-zero outside LOAD_W; at most one bit set at any time.
REQ-025 A new start SHALL be accepted in the same cycle done is high (back-to-back jobs).
REQ-026 Counters SHALL be sized so M=2^VW-1 completes without overflow.

Reset
REQ-027 reset SHALL force IDLE and zero all counters on the next edge, including mid-job; reset has priority over start.
REQ-028 During and after reset: busy, done, w_rd_en, a_rd_en = 0; pe_load_row, west_valid, out_valid = 0; addresses = 0.

Verification
REQ-029 N=4, keep_w=0, M=3: w_rd_addr 0,1,2,3 then pe_load_row 0001,0010,0100,1000; a_rd_addr 0,1,2; done 11 cycles after LOAD_W exit (s=0..10).
REQ-030 N=4, M=3, with PE array + memories in bench: per-column results equal reference A*W matrix product (int8 x int8, 32-bit sum), out_valid high 3 cycles per column, column c starting at s=5+c.
REQ-031 keep_w=1, M=1: no w_rd_en, no pe_load_row; west_valid[r] only at s=1+r; done at s=2N-1+1.
REQ-032 M=0, keep_w=0: load phase only, then done pulse; M=0, keep_w=1: done one cycle after start, no memory reads.
REQ-033 reset asserted at s=4 of a job: next cycle all outputs 0, busy=0, no done; fresh start then runs to completion normally.
REQ-034 start held high throughout two jobs: second job starts on done cycle; start pulses mid-job ignored (M unchanged, single done per job).

Source files
------------

// File: rtl/sa_sequencer.sv
// Control sequencer for an N x N weight-stationary int8 systolic array:
// loads weight rows, streams skewed activation vectors, and flags valid results.
module sa_sequencer #(
   parameter int unsigned N  = 4,
   parameter int unsigned VW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 keep_w,
   input  logic [VW-1:0]        num_vecs,
   output logic                 busy,
   output logic                 done,
   output logic                 w_rd_en,
   output logic [$clog2(N)-1:0] w_rd_addr,
   output logic [N-1:0]         pe_load_row,
   output logic                 a_rd_en,
   output logic [VW-1:0]        a_rd_addr,
   output logic [N-1:0]         west_valid,
   output logic [N-1:0]         out_valid
);

   localparam int unsigned AW = $clog2(N);
   // Two spare bits let s reach M+2N-1 even for the largest M.
   localparam int unsigned CW = VW + 2;

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [VW-1:0]   m_q, m_d;
   logic [CW-1:0]   m_ext;
   logic [CW-1:0]   s_last;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            w_rd_en_q, w_rd_en_d;
   logic [AW-1:0]   w_rd_addr_q, w_rd_addr_d;
   logic [N-1:0]    pe_load_row_q, pe_load_row_d;
   logic            a_rd_en_q, a_rd_en_d;
   logic [VW-1:0]   a_rd_addr_q, a_rd_addr_d;
   logic [N-1:0]    west_valid_q, west_valid_d;
   logic [N-1:0]    out_valid_q, out_valid_d;

   // Next state, then outputs decoded from the next state so they register in step with it.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      m_d           = m_q;
      done_d        = 1'b0;
      w_rd_en_d     = 1'b0;
      w_rd_addr_d   = '0;
      pe_load_row_d = '0;
      a_rd_en_d     = 1'b0;
      a_rd_addr_d   = '0;
      west_valid_d  = '0;
      out_valid_d   = '0;
      s_last        = CW'(m_q) + CW'(2 * N - 1);

      case (state_q)
         IDLE: begin
            if (start) begin
               m_d   = num_vecs;
               cnt_d = '0;
               if (!keep_w) begin
                  state_d = LOAD_W;
               end else if (num_vecs != '0) begin
                  state_d = STREAM;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         LOAD_W: begin
            if (cnt_q == CW'(N)) begin
               cnt_d = '0;
               if (m_q != '0) begin
                  state_d = STREAM;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STREAM: begin
            if (cnt_q == s_last) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
      m_ext  = CW'(m_d);

      if (state_d == LOAD_W) begin
         if (cnt_d < CW'(N)) begin
            w_rd_en_d   = 1'b1;
            w_rd_addr_d = AW'(cnt_d);
         end
         for (int unsigned i = 0; i < N; i++) begin
            pe_load_row_d[i] = (cnt_d == CW'(i + 1));
         end
      end

      // Row r sees vector m at s=m+1+r; column c emits vector m at s=m+N+1+c.
      if (state_d == STREAM) begin
         if (cnt_d < m_ext) begin
            a_rd_en_d   = 1'b1;
            a_rd_addr_d = VW'(cnt_d);
         end
         for (int unsigned i = 0; i < N; i++) begin
            west_valid_d[i] = (cnt_d >= CW'(i + 1)) && (cnt_d <= m_ext + CW'(i));
            out_valid_d[i]  = (cnt_d >= CW'(N + 1 + i)) && (cnt_d <= m_ext + CW'(N + i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         m_q           <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         w_rd_en_q     <= 1'b0;
         w_rd_addr_q   <= '0;
         pe_load_row_q <= '0;
         a_rd_en_q     <= 1'b0;
         a_rd_addr_q   <= '0;
         west_valid_q  <= '0;
         out_valid_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         m_q           <= m_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         w_rd_en_q     <= w_rd_en_d;
         w_rd_addr_q   <= w_rd_addr_d;
         pe_load_row_q <= pe_load_row_d;
         a_rd_en_q     <= a_rd_en_d;
         a_rd_addr_q   <= a_rd_addr_d;
         west_valid_q  <= west_valid_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign w_rd_en     = w_rd_en_q;
   assign w_rd_addr   = w_rd_addr_q;
   assign pe_load_row = pe_load_row_q;
   assign a_rd_en     = a_rd_en_q;
   assign a_rd_addr   = a_rd_addr_q;
   assign west_valid  = west_valid_q;
   assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_sa_sequencer.sv
// Directed bench for sa_sequencer with a behavioural PE array and weight/activation memories.
module tb_sa_sequencer;

   localparam int N   = 4;
   localparam int VW  = 16;
   localparam int LIM = 64;

   logic          clk = 1'b0;
   logic          reset, start, keep_w;
   logic [VW-1:0] num_vecs;
   logic          busy, done, w_rd_en, a_rd_en;
   logic [1:0]    w_rd_addr;
   logic [3:0]    pe_load_row, west_valid, out_valid;
   logic [VW-1:0] a_rd_addr;

   int checks = 0;
   int errors = 0;

   sa_sequencer #(.N(N), .VW(VW)) dut (
      .clk(clk), .reset(reset), .start(start), .keep_w(keep_w), .num_vecs(num_vecs),
      .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
      .pe_load_row(pe_load_row), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
      .west_valid(west_valid), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Memories and array model; int8 values held in int.
   int wmem [N][N];
   int amem [8][N];
   int w_dat [N];
   int a_dat [N];
   int sk    [N][N];
   int west_in [N];
   int wpe   [N][N];
   int east  [N][N];
   int south [N][N];

   always_comb begin
      for (int r = 0; r < N; r++) begin
         west_in[r] = 0;
         if (west_valid[r]) west_in[r] = (r == 0) ? a_dat[0] : sk[r][r-1];
      end
   end

   function automatic int pe_a(input int r, input int c);
      return (c == 0) ? west_in[r] : east[r][c-1];
   endfunction

   function automatic int pe_p(input int r, input int c);
      return (r == 0) ? 0 : south[r-1][c];
   endfunction

   always @(posedge clk) begin
      if (w_rd_en) for (int c = 0; c < N; c++) w_dat[c] <= wmem[w_rd_addr][c];
      if (a_rd_en) for (int r = 0; r < N; r++) a_dat[r] <= amem[a_rd_addr[2:0]][r];
      for (int r = 0; r < N; r++) begin
         sk[r][0] <= a_dat[r];
         for (int j = 1; j < N; j++) sk[r][j] <= sk[r][j-1];
         for (int c = 0; c < N; c++) begin
            if (pe_load_row[r]) wpe[r][c] <= w_dat[c];
            east[r][c]  <= pe_a(r, c);
            south[r][c] <= pe_p(r, c) + pe_a(r, c) * wpe[r][c];
         end
      end
   end

   function automatic int ref_dot(input int m, input int c);
      int acc = 0;
      for (int r = 0; r < N; r++) acc += amem[m][r] * wmem[r][c];
      return acc;
   endfunction

   // Expected control word {busy,done,w_en,w_addr,load_row,a_en,a_addr,west_valid,out_valid}
   // at cycle t after the accepting edge.
   function automatic logic [33:0] expect_at(input logic kw, input int m, input int t);
      logic b, d, we, ae;
      logic [1:0]  wa;
      logic [3:0]  pl, wv, ov;
      logic [15:0] aa;
      int ls, s, fin, k;
      b = 0; d = 0; we = 0; ae = 0; wa = '0; pl = '0; wv = '0; ov = '0; aa = '0;
      ls  = kw ? 0 : N + 1;
      fin = (m == 0) ? 1 + ls : 1 + ls + m + 2 * N;
      s   = t - 1 - ls;
      b   = (t >= 1) && (t < fin);
      d   = (t == fin);
      if (t >= 1 && t <= ls) begin
         k = t - 1;
         if (k < N) begin we = 1; wa = 2'(k); end
         if (k >= 1) pl = 4'(1 << (k - 1));
      end
      if (m > 0 && t > ls && t < fin) begin
         if (s < m) begin ae = 1; aa = 16'(s); end
         for (int r = 0; r < N; r++) begin
            wv[r] = (s >= 1 + r) && (s <= m + r);
            ov[r] = (s >= N + 1 + r) && (s <= m + N + r);
         end
      end
      return {b, d, we, wa, pl, ae, aa, wv, ov};
   endfunction

   logic [33:0] tr_ctl [LIM];
   int          tr_res [LIM][N];

   function automatic logic [33:0] ctl_now();
      return {busy, done, w_rd_en, (w_rd_en ? w_rd_addr : 2'b00), pe_load_row,
              a_rd_en, (a_rd_en ? a_rd_addr : 16'h0000), west_valid, out_valid};
   endfunction

   // Issue one start and record every cycle until done (bounded by LIM).
   task automatic run_job(input logic kw, input int m, output int done_t);
      done_t = 0;
      @(negedge clk);
      start = 1; keep_w = kw; num_vecs = VW'(m);
      for (int t = 1; t < LIM; t++) begin
         @(negedge clk);
         start = 0;
         tr_ctl[t] = ctl_now();
         for (int c = 0; c < N; c++) tr_res[t][c] = south[N-1][c];
         if (done) begin done_t = t; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1; start = 1; keep_w = 0; num_vecs = 16'd3;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, pe_load_row, west_valid, out_valid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b wen=%b aen=%b plr=%b wv=%b ov=%b, required all 0",
                  busy, done, w_rd_en, a_rd_en, pe_load_row, west_valid, out_valid);
      end
      reset = 0; start = 0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic check_job(input string nm, input logic kw, input int m, input int dt, input logic chk_res);
      int fin, ls, s;
      logic [33:0] e;
      ls  = kw ? 0 : N + 1;
      fin = (m == 0) ? 1 + ls : 1 + ls + m + 2 * N;
      checks++;
      if (dt !== fin) begin
         errors++;
         $display("FAIL %s_done_cycle: got %0d, required %0d", nm, dt, fin);
      end
      for (int t = 1; t <= fin; t++) begin
         e = expect_at(kw, m, t);
         checks++;
         if (tr_ctl[t] !== e) begin
            errors++;
            $display("FAIL %s_ctl t=%0d: got %h, required %h", nm, t, tr_ctl[t], e);
         end
         s = t - 1 - ls;
         for (int c = 0; c < N; c++) begin
            if (chk_res && e[c]) begin
               checks++;
               if (tr_res[t][c] !== ref_dot(s - (N + 1 + c), c)) begin
                  errors++;
                  $display("FAIL %s_result t=%0d col=%0d: got %0d, required %0d",
                           nm, t, c, tr_res[t][c], ref_dot(s - (N + 1 + c), c));
               end
            end
         end
      end
   endtask

   task automatic test_load_stream();
      int dt;
      run_job(1'b0, 3, dt);
      check_job("load_m3", 1'b0, 3, dt, 1'b1);
   endtask

   task automatic test_keep_w();
      int dt;
      run_job(1'b1, 1, dt);
      check_job("keep_m1", 1'b1, 1, dt, 1'b1);
   endtask

   task automatic test_zero_vecs();
      int dt;
      run_job(1'b0, 0, dt);
      check_job("load_m0", 1'b0, 0, dt, 1'b0);
      run_job(1'b1, 0, dt);
      check_job("keep_m0", 1'b1, 0, dt, 1'b0);
   endtask

   task automatic test_reset_mid();
      int dt;
      @(negedge clk);
      start = 1; keep_w = 1; num_vecs = 16'd3;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         start = 0;
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      checks++;
      if (ctl_now() !== '0 || a_rd_addr !== '0 || w_rd_addr !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got %h, required 0", ctl_now());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_done: got busy=%b done=%b, required 0 0", busy, done);
      end
      run_job(1'b1, 3, dt);
      check_job("after_reset", 1'b1, 3, dt, 1'b1);
   endtask

   task automatic test_back_to_back();
      int ndone = 0, d1 = 0, d2 = 0, ov1 = 0, ov2 = 0;
      logic b11 = 1'b1, b12 = 1'b0;
      @(negedge clk);
      start = 1; keep_w = 1; num_vecs = 16'd2;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (t == 1) num_vecs = 16'd5;
         if (t == 12) start = 0;
         if (t == 11) b11 = busy;
         if (t == 12) b12 = busy;
         if (out_valid[0]) begin
            if (t <= 11) ov1++; else ov2++;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) d1 = t; else if (ndone == 2) d2 = t;
         end
      end
      checks++;
      if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", ndone); end
      checks++;
      if (d1 !== 11) begin errors++; $display("FAIL b2b_done1: got t=%0d, required t=11", d1); end
      checks++;
      if (d2 !== 25) begin errors++; $display("FAIL b2b_done2: got t=%0d, required t=25", d2); end
      checks++;
      if (b11 !== 1'b0 || b12 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy: got %b%b at t=11/12, required 01", b11, b12);
      end
      checks++;
      if (ov1 !== 2 || ov2 !== 5) begin
         errors++;
         $display("FAIL b2b_vec_count: got %0d/%0d col0 results, required 2/5", ov1, ov2);
      end
   endtask

   initial begin
      wmem = '{'{1, -2, 3, 127}, '{-128, 5, 0, 2}, '{7, -1, 4, -3}, '{2, 2, -6, 1}};
      amem = '{'{3, -1, 2, -128}, '{127, 0, -5, 1}, '{-7, 8, 1, 2}, '{1, 1, 1, 1},
               '{-128, -128, 127, 127}, '{4, -3, 2, -1}, '{0, 9, 0, -9}, '{5, 5, 5, 5}};
      reset = 1; start = 0; keep_w = 0; num_vecs = '0;
      test_reset();
      test_load_stream();
      test_keep_w();
      test_zero_vecs();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
